// File: rtl/uart_byte_tx_if.sv
// -----------------------------------------------------------------------------
// uart_byte_tx_if
//   Byte stream link between the 32-bit-to-byte separator (master) and the
//   UART byte transmitter (slave).
//
//   Signals
//     data_i   [7:0]  byte from the separator
//     valid_i         data_i is valid this cycle (push request)
//     ready_o         transmitter can take bytes; the separator may still
//                     issue one byte in the cycle after ready_o falls
//
//   Modports
//     master : separator side  (drives data_i/valid_i, reads ready_o)
//     slave  : transmitter side (reads data_i/valid_i, drives ready_o)
// -----------------------------------------------------------------------------
interface uart_byte_tx_if;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;

  modport master (
    output data_i,
    output valid_i,
    input  ready_o
  );

  modport slave (
    input  data_i,
    input  valid_i,
    output ready_o
  );
endinterface

// File: rtl/uart_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
//   Queues bytes from the separator in a small FIFO and serialises them onto
//   a UART TX line, 8N1, LSB first. Frames leave back to back while the FIFO
//   holds data; each serial bit lasts exactly CLKS_PER_BIT clocks.
//
//   Ports
//     clk         system clock, rising edge
//     rstn        asynchronous active-low reset; aborts any frame in flight
//     up          byte stream link (slave modport: data_i, valid_i, ready_o)
//     tx_o        UART serial line, idle high, registered
//     busy_o      a frame is on the line or the FIFO is non-empty
//     overflow_o  sticky: a byte was dropped because the FIFO was full
//     state_o     current transmit state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
//   Handshake: a byte is taken whenever valid_i is high and there is room
//   (FIFO not full, or a pop happens in the same cycle); there is no stall,
//   so a byte offered without room is dropped and flagged on overflow_o.
//   ready_o is high while at most FIFO_DEPTH-2 entries are used, which leaves
//   room for the one byte the separator can still issue after ready_o falls.
//
//   CLKS_PER_BIT = CLK_FREQ / BAUD_RATE must be >= 2; FIFO_DEPTH must be a
//   power of two and >= 4.
// -----------------------------------------------------------------------------
module uart_byte_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  uart_byte_tx_if.slave up,
  output logic          tx_o,
  output logic          busy_o,
  output logic          overflow_o,
  output logic [1:0]    state_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   READY_MAX  = (PTR_W + 1)'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_d;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;

  logic push, pop, drop, fifo_empty, baud_last;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  assign fifo_empty = (count_q == '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push       = up.valid_i && ((count_q != COUNT_FULL) || pop);
  assign drop       = up.valid_i && !push;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  assign up.ready_o = (count_q <= READY_MAX);
  assign busy_o     = (state_q != IDLE) || !fifo_empty;
  assign state_o    = state_q;

  // ---------------------------------------------------------------------------
  // Transmit FSM: next state, baud counter, bit index, pop request
  // ---------------------------------------------------------------------------
  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end

      START: begin
        if (baud_last) begin
          baud_d  = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit when data is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase
  end

  assign shift_d = pop ? mem[rd_ptr_q] : shift_q;

  // The line level is computed from the next state so the registered tx_o
  // changes on the same edge as the state register, without a cycle of lag.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      tx_o       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_o <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_o    <= tx_d;
      count_q <= count_d;
      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (drop) begin
        overflow_o <= 1'b1;
      end
    end
  end

  // Storage needs no reset: reset empties the FIFO through the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= up.data_i;
    end
  end

endmodule
